inst_fetcher: RTL and testbench

- Instruction fetch front end; produces the 32-bit `inst` word consumed by the instruction decoder, plus its PC.
- Owns the fetch PC and issues word requests to instruction memory over a request/response port.
- Buffers returned words in a small FIFO and presents them to the decoder with a valid/ready handshake.
- Accepts a redirect (branch/jump) from the execute stage, which flushes the FIFO and discards stale in-flight responses.

---
 rtl/inst_fetcher_if.sv | 25 ++
 rtl/inst_fetcher.sv | 121 ++++++++++++
 tb/tb_inst_fetcher.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetcher_if.sv
// Instruction-memory port of the fetch unit: request (valid/ready/addr)
// and in-order response (valid/data). master = fetcher, slave = memory.
interface inst_fetcher_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );
endinterface

// File: rtl/inst_fetcher.sv
// Fetch front end: PC, credit-limited imem requests, response FIFO to decoder.
// Ports: clk, rst, imem (master), inst_valid/ready/inst/inst_pc, redirect/_pc.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  inst_fetcher_if.master imem,
  output logic           inst_valid,
  input  logic           inst_ready,
  output logic [31:0]    inst,
  output logic [31:0]    inst_pc,
  input  logic           redirect,
  input  logic [31:0]    redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0] pc;
  cnt_t        inflight;
  cnt_t        discard;
  cnt_t        fifo_cnt;
  ptr_t        tag_wr;
  ptr_t        tag_rd;
  ptr_t        fifo_wr;
  ptr_t        fifo_rd;

  logic [31:0] tag_q     [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [31:0] fifo_pc   [DEPTH];

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        resp_fire;
  logic        resp_drop;
  logic        push;
  logic        pop;

  // FIFO occupancy counts toward credits even if it pops this cycle.
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_cnt};

  assign imem.imem_req_valid = !rst && !redirect &&
                               (credit_used < {1'b0, DEPTH_C});
  assign imem.imem_req_addr  = pc & ~32'd3;

  assign req_fire  = imem.imem_req_valid && imem.imem_req_ready;
  assign resp_fire = imem.imem_resp_valid;
  // A response landing with a redirect belongs to the old stream.
  assign resp_drop = resp_fire && (redirect || discard != '0);
  assign push      = resp_fire && !resp_drop;
  assign pop       = inst_valid && inst_ready;

  assign inst_valid = (fifo_cnt != '0);
  assign inst       = inst_valid ? fifo_data[fifo_rd] : 32'd0;
  assign inst_pc    = inst_valid ? fifo_pc[fifo_rd]   : 32'd0;

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_q[tag_wr] <= imem.imem_req_addr;
    end
    if (push) begin
      fifo_data[fifo_wr] <= imem.imem_resp_data;
      fifo_pc[fifo_wr]   <= tag_q[tag_rd];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      fifo_cnt <= '0;
      tag_wr   <= '0;
      tag_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      if (req_fire) begin
        tag_wr <= tag_wr + ptr_t'(1);
      end
      if (resp_fire) begin
        tag_rd <= tag_rd + ptr_t'(1);
      end
      if (redirect) begin
        pc       <= redirect_pc & ~32'd3;
        inflight <= inflight - cnt_t'(resp_fire);
        discard  <= inflight - cnt_t'(resp_fire);
        fifo_cnt <= '0;
        fifo_rd  <= fifo_wr;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        inflight <= inflight + cnt_t'(req_fire)
                             - cnt_t'(resp_fire);
        if (resp_drop) begin
          discard <= discard - cnt_t'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + ptr_t'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + ptr_t'(1);
        end
        fifo_cnt <= fifo_cnt + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  // Memory must never answer a request that was not issued.
  a_resp_has_req: assert property (
    @(posedge clk) disable iff (rst)
    imem.imem_resp_valid |-> (inflight != '0)
  );
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: in-order latency-programmable memory model,
// per-cycle vector table plus redirect / wrap / async-reset sequences.
module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetcher_if bus ();

  inst_fetcher #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (bus),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t pend[$];
  int    lat = 1;
  int    cyc = 0;

  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'd0;
  end

  always @(posedge clk) begin
    logic        acc;
    logic        rv;
    logic [31:0] a;
    acc = bus.imem_req_valid && bus.imem_req_ready;
    a   = bus.imem_req_addr;
    rv  = bus.imem_resp_valid;
    cyc = cyc + 1;
    #1;
    if (rst) begin
      pend.delete();
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'd0;
    end else begin
      if (rv && pend.size() > 0) void'(pend.pop_front());
      if (acc) pend.push_back('{a, cyc + lat});
      if (pend.size() > 0 && pend[0].due <= cyc + 1) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = mem_word(pend[0].addr);
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = 32'd0;
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    inst_ready  = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(bus.imem_req_valid), 0);
    check("rst_inst_valid", 32'(inst_valid), 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Call at negedge+1; checks n consecutive deliveries from base.
  task automatic expect_stream(input string nm, input logic [31:0] base,
                               input int n);
    int got;
    int k;
    logic [31:0] e;
    got = 0;
    k   = 0;
    while (got < n && k < 40) begin
      if (inst_valid) begin
        e = base + 32'(4 * got);
        check({nm, "_pc"}, inst_pc, e);
        check({nm, "_data"}, inst, mem_word(e));
        got++;
      end
      @(negedge clk);
      #1;
      k++;
    end
    if (got < n) check({nm, "_timeout"}, 32'(got), 32'(n));
  endtask

  task automatic wait_inst(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      #1;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    bit          do_rst;
    logic        rdy;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(bit r, logic rdy, logic rv, logic [31:0] a,
                              logic iv, logic [31:0] p);
    vec_t v;
    v.do_rst = r;
    v.rdy    = rdy;
    v.rv     = rv;
    v.addr   = a;
    v.iv     = iv;
    v.pc     = p;
    return v;
  endfunction

  localparam int NV = 22;

  initial begin
    vec_t vt [NV];
    bit   ok;
    logic [31:0] stale;

    rst                = 1'b1;
    inst_ready         = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = 32'd0;
    bus.imem_req_ready = 1'b1;

    // 1-cycle memory, decoder always ready: credits allow 2 per 3 cycles.
    vt[0]  = mk(1, 1, 1, 32'h00, 0, 0);
    vt[1]  = mk(0, 1, 1, 32'h04, 0, 0);
    vt[2]  = mk(0, 1, 0, 0,      1, 32'h00);
    vt[3]  = mk(0, 1, 1, 32'h08, 1, 32'h04);
    vt[4]  = mk(0, 1, 1, 32'h0C, 0, 0);
    vt[5]  = mk(0, 1, 0, 0,      1, 32'h08);
    vt[6]  = mk(0, 1, 1, 32'h10, 1, 32'h0C);
    vt[7]  = mk(0, 1, 1, 32'h14, 0, 0);
    // Decoder stalled 10 cycles: two requests, then full and held.
    vt[8]  = mk(1, 0, 1, 32'h00, 0, 0);
    vt[9]  = mk(0, 0, 1, 32'h04, 0, 0);
    for (int i = 10; i < 18; i++) vt[i] = mk(0, 0, 0, 0, 1, 32'h00);
    vt[18] = mk(0, 1, 0, 0,      1, 32'h00);
    vt[19] = mk(0, 1, 1, 32'h08, 1, 32'h04);
    vt[20] = mk(0, 1, 1, 32'h0C, 0, 0);
    vt[21] = mk(0, 1, 0, 0,      1, 32'h08);

    lat = 1;
    for (int i = 0; i < NV; i++) begin
      if (vt[i].do_rst) do_reset();
      inst_ready = vt[i].rdy;
      #1;
      check($sformatf("v%0d_req_valid", i), 32'(bus.imem_req_valid),
            32'(vt[i].rv));
      if (vt[i].rv)
        check($sformatf("v%0d_req_addr", i), bus.imem_req_addr, vt[i].addr);
      check($sformatf("v%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].iv));
      if (vt[i].iv) begin
        check($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].pc);
        check($sformatf("v%0d_inst", i), inst, mem_word(vt[i].pc));
      end
      @(negedge clk);
    end

    // Redirect with two stale requests in flight, 3-cycle memory.
    lat = 3;
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h10;
    #1;
    check("t3_rdr_noreq", 32'(bus.imem_req_valid), 0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t3_addr10", bus.imem_req_addr, 32'h10);
    @(negedge clk);
    #1;
    check("t3_addr14", bus.imem_req_addr, 32'h14);
    @(negedge clk);
    #1;
    check("t3_full", 32'(bus.imem_req_valid), 0);
    redirect    = 1'b1;
    redirect_pc = 32'h203;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t3_discard", 32'(dut.discard), 2);
    check("t3_stall", 32'(bus.imem_req_valid), 0);
    @(negedge clk);
    #1;
    check("t3_req_valid", 32'(bus.imem_req_valid), 1);
    check("t3_addr200", bus.imem_req_addr, 32'h200);
    expect_stream("t3", 32'h200, 2);

    // Redirect coinciding with a response and a decoder handshake.
    lat = 2;
    do_reset();
    inst_ready = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (inst_valid && bus.imem_resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t4_found", 32'(ok), 1);
    stale       = inst_pc;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t4_flushed", 32'(inst_valid), 0);
    check("t4_discard", 32'(dut.discard), 0);
    check("t4_inflight", 32'(dut.inflight), 0);
    check("t4_req_addr", bus.imem_req_addr, 32'h100);
    check("t4_consumed", stale, 32'h0);
    expect_stream("t4", 32'h100, 3);

    // Redirect to the top word: PC wraps to 0.
    lat = 1;
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    check("t5_rdr_noreq", 32'(bus.imem_req_valid), 0);
    @(negedge clk);
    redirect = 1'b0;
    #1;
    check("t5_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    #1;
    check("t5_req_wrap", 32'(bus.imem_req_valid), 1);
    check("t5_addr_wrap", bus.imem_req_addr, 32'h0);
    expect_stream("t5", 32'hFFFF_FFFC, 3);

    // Async reset mid-stream with requests in flight.
    lat = 3;
    do_reset();
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    wait_inst(20, ok);
    check("t6_pre_valid", 32'(ok), 1);
    check("t6_pre_pc", inst_pc, 32'h400);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", 32'(inst_valid), 0);
    check("t6_rst_inst", inst, 0);
    check("t6_rst_pc", inst_pc, 0);
    check("t6_rst_req", 32'(bus.imem_req_valid), 0);
    check("t6_rst_inflight", 32'(dut.inflight), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_req_valid", 32'(bus.imem_req_valid), 1);
    check("t6_req_addr", bus.imem_req_addr, 32'h0);
    expect_stream("t6", 32'h0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
